// File: rtl/tff_mod_counter.sv
// Modulo counter whose state is a bank of T flip-flops: each bit toggles when
// the requested next value differs from the current one.
module tff_mod_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULO    = 10,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             err
);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_TOG  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    // One extra bit so MODULO == 2**WIDTH is representable and nothing is out of range.
    localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] toggled;
    logic             err_reg;
    logic             err_next;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (q_reg == MAX_VAL);
    assign at_zero = (q_reg == '0);
    assign toggled = q_reg ^ din;

    always_comb begin
        q_next   = q_reg;
        err_next = 1'b0;
        if (load) begin
            if ({1'b0, din} < MOD_W) begin
                q_next = din;
            end else begin
                err_next = 1'b1;
            end
        end else if (en) begin
            case (mode)
                MODE_UP:   q_next = at_max  ? '0      : q_reg + WIDTH'(1);
                MODE_DOWN: q_next = at_zero ? MAX_VAL : q_reg - WIDTH'(1);
                MODE_TOG: begin
                    if ({1'b0, toggled} < MOD_W) begin
                        q_next = toggled;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                MODE_HOLD: q_next = q_reg;
                default:   q_next = q_reg;
            endcase
        end
    end

    assign t_vec = q_reg ^ q_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_tff
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_reg[gi] <= RST_Q[gi];
                end else begin
                    q_reg[gi] <= q_reg[gi] ^ t_vec[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign q    = q_reg;
    assign qbar = ~q_reg;
    assign err  = err_reg;
    assign tc   = en & ~load & ~rst &
                  (((mode == MODE_UP) & at_max) | ((mode == MODE_DOWN) & at_zero));

endmodule

// File: tb/tb_tff_mod_counter.sv
// Scoreboard bench for tff_mod_counter: a directed driver queues hand-computed
// expectations, a negedge monitor pops and compares them against the selected DUT.
module tb_tff_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       load = 1'b0;
    logic [3:0] din = 4'd0;

    logic [3:0] q10, qbar10, q16, qbar16;
    logic       tc10, err10, tc16, err16;

    always #5 clk = ~clk;

    tff_mod_counter #(.WIDTH(4), .MODULO(10), .RESET_VAL(0)) u_dut10 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .din(din),
        .q(q10), .qbar(qbar10), .tc(tc10), .err(err10)
    );

    tff_mod_counter #(.WIDTH(4), .MODULO(16), .RESET_VAL(0)) u_dut16 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .din(din),
        .q(q16), .qbar(qbar16), .tc(tc16), .err(err16)
    );

    typedef struct {
        int         id;
        bit         sel16;
        logic [3:0] q;
        logic       err;
        logic       tc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   txn_id   = 0;

    task automatic check(input string name, input int id, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL txn %0d %s: got %h expected %h", id, name, act, req);
    endtask

    // Drives one transaction for the next edge and queues its expected outcome.
    task automatic drive(input bit s16, input logic r, input logic ld, input logic e,
                         input logic [1:0] m, input logic [3:0] d,
                         input logic etc, input logic [3:0] eq, input logic eerr);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; load = ld; en = e; mode = m; din = d;
        x.id = txn_id; x.sel16 = s16; x.q = eq; x.err = eerr; x.tc = etc;
        txn_id++;
        sb.push_back(x);
    endtask

    exp_t last;
    bit   have_last = 1'b0;

    always @(negedge clk) begin
        if (have_last) begin
            check("q",    last.id, last.sel16 ? q16 : q10, last.q);
            check("err",  last.id, {3'b0, last.sel16 ? err16 : err10}, {3'b0, last.err});
            check("qbar", last.id, last.sel16 ? qbar16 : qbar10, ~last.q);
            $display("txn %0d dut%0d: q=%h err=%b (exp q=%h err=%b)", last.id,
                     last.sel16 ? 16 : 10, last.sel16 ? q16 : q10,
                     last.sel16 ? err16 : err10, last.q, last.err);
            have_last = 1'b0;
        end
        if (sb.size() > 0) begin
            last = sb.pop_front();
            check("tc", last.id, {3'b0, last.sel16 ? tc16 : tc10}, {3'b0, last.tc});
            have_last = 1'b1;
        end
    end

    initial begin
        // reset
        drive(0, 1, 0, 0, 2'b00, 4'd0, 0, 4'd0, 0);
        // count up 12 edges, wrap at 9
        for (int i = 1; i <= 12; i++) begin
            drive(0, 0, 0, 1, 2'b00, 4'd0, (i == 10), 4'((i) % 10), 0);
        end
        // load 3 then count down 5 edges
        drive(0, 0, 1, 0, 2'b00, 4'd3, 0, 4'd3, 0);
        drive(0, 0, 0, 1, 2'b01, 4'd0, 0, 4'd2, 0);
        drive(0, 0, 0, 1, 2'b01, 4'd0, 0, 4'd1, 0);
        drive(0, 0, 0, 1, 2'b01, 4'd0, 0, 4'd0, 0);
        drive(0, 0, 0, 1, 2'b01, 4'd0, 1, 4'd9, 0);
        drive(0, 0, 0, 1, 2'b01, 4'd0, 0, 4'd8, 0);
        // illegal load, then idle clears err
        drive(0, 0, 1, 0, 2'b00, 4'd12, 0, 4'd8, 1);
        drive(0, 0, 0, 0, 2'b00, 4'd0, 0, 4'd8, 0);
        // en=0 in down mode at q=0 must not raise tc: load 0 first
        drive(0, 0, 1, 0, 2'b00, 4'd0, 0, 4'd0, 0);
        drive(0, 0, 0, 0, 2'b01, 4'd0, 0, 4'd0, 0);
        // toggle mode
        drive(0, 0, 1, 0, 2'b00, 4'd5, 0, 4'd5, 0);
        drive(0, 0, 0, 1, 2'b10, 4'b0011, 0, 4'd6, 0);
        drive(0, 0, 0, 1, 2'b10, 4'b1000, 0, 4'd6, 1);
        drive(0, 0, 0, 1, 2'b10, 4'b0000, 0, 4'd6, 0);
        drive(0, 0, 0, 1, 2'b11, 4'd0, 0, 4'd6, 0);
        // reset, count to 7, load wins over mode, reset wins over illegal load
        drive(0, 1, 0, 1, 2'b00, 4'd0, 0, 4'd0, 0);
        for (int i = 1; i <= 7; i++) begin
            drive(0, 0, 0, 1, 2'b00, 4'd0, 0, 4'(i), 0);
        end
        drive(0, 0, 1, 1, 2'b00, 4'd2, 0, 4'd2, 0);
        drive(0, 1, 1, 1, 2'b00, 4'd12, 0, 4'd0, 0);
        // MODULO=16 instance
        drive(1, 1, 0, 0, 2'b00, 4'd0, 0, 4'd0, 0);
        drive(1, 0, 1, 0, 2'b00, 4'd15, 0, 4'd15, 0);
        drive(1, 0, 0, 1, 2'b00, 4'd0, 1, 4'd0, 0);
        drive(1, 0, 0, 1, 2'b10, 4'hF, 0, 4'd15, 0);
        drive(1, 0, 0, 1, 2'b10, 4'hA, 0, 4'd5, 0);
        drive(1, 0, 0, 1, 2'b01, 4'd0, 0, 4'd4, 0);
        // idle
        @(posedge clk);
        #1;
        rst = 1'b0; load = 1'b0; en = 1'b0; mode = 2'b11; din = 4'd0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0 && !have_last) n_pass++;
        else $display("FAIL drain: %0d entries still pending, required 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
